// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// KEYPAD_SCAN_REPEAT_EN (in keypad_scan) enables auto-repeat.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      PRESSED,
      RELEASE
   } state_t;

   localparam logic [3:0] COL_INIT = 4'b1110;
   localparam int REPEAT_FIRST = 16;
   localparam int REPEAT_NEXT = 4;

   // Lowest-numbered low bit wins.
   function automatic logic [1:0] low_idx(input logic [3:0] v);
      if (!v[0]) return 2'd0;
      else if (!v[1]) return 2'd1;
      else if (!v[2]) return 2'd2;
      else return 2'd3;
   endfunction

   function automatic logic [3:0] rotate(input logic [3:0] v);
      return {v[2:0], v[3]};
   endfunction

endpackage

// File: rtl/keypad_tick.sv
// Free-running scan tick: one-cycle pulse every CLK_DIV clocks.
// Used by keypad_scan; no configuration macros.
module keypad_tick #(
   parameter int CLK_DIV = 50000
) (
   input  logic CLK,
   input  logic reset,
   output logic tick
);

   localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (reset) cnt <= '0;
      else if (tick) cnt <= '0;
      else cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with debounce and a held-until-ack event output.
// Define KEYPAD_SCAN_REPEAT_EN to re-raise events while a key stays held.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int CLK_DIV = 50000,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic       CLK,
   input  logic       reset,
   output logic [3:0] col_out,
   input  logic [3:0] row_in,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_held,
   output logic       overrun
);

   localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_TICKS - 1);

   state_t     state, state_n;
   logic [3:0] sync1, rows;
   logic [3:0] cand, cand_n;
   logic [3:0] col_n;
   logic [3:0] cnt, cnt_n;
   logic [3:0] code_now;
   logic       tick, idle;
   logic       evt, evt_n;
   logic       held_clr;

`ifdef KEYPAD_SCAN_REPEAT_EN
   localparam logic [4:0] REP_FIRST_LAST = 5'(REPEAT_FIRST - 1);
   localparam logic [4:0] REP_NEXT_LAST = 5'(REPEAT_NEXT - 1);
   logic [4:0] rep, rep_n;
   logic       first, first_n;
`endif

   keypad_tick #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .CLK  (CLK),
      .reset(reset),
      .tick (tick)
   );

   assign idle = &rows;
   assign code_now = {low_idx(rows), low_idx(col_out)};

   always_ff @(posedge CLK) begin
      if (reset) begin
         sync1   <= '1;
         rows    <= '1;
         state   <= SCAN;
         col_out <= COL_INIT;
         cand    <= '0;
         cnt     <= '0;
         evt     <= 1'b0;
      end else begin
         sync1   <= row_in;
         rows    <= sync1;
         state   <= state_n;
         col_out <= col_n;
         cand    <= cand_n;
         cnt     <= cnt_n;
         evt     <= evt_n;
      end
   end

`ifdef KEYPAD_SCAN_REPEAT_EN
   always_ff @(posedge CLK) begin
      if (reset) begin
         rep   <= '0;
         first <= 1'b1;
      end else begin
         rep   <= rep_n;
         first <= first_n;
      end
   end
`endif

   always_comb begin
      state_n  = state;
      col_n    = col_out;
      cand_n   = cand;
      cnt_n    = cnt;
      evt_n    = 1'b0;
      held_clr = 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
      rep_n   = rep;
      first_n = first;
`endif
      if (tick) begin
         unique case (state)
            SCAN: begin
               if (idle) begin
                  col_n = rotate(col_out);
               end else begin
                  state_n = DEBOUNCE;
                  cand_n  = code_now;
                  cnt_n   = '0;
               end
            end
            DEBOUNCE: begin
               if (idle || code_now != cand) begin
                  state_n = SCAN;
                  cnt_n   = '0;
               end else if (cnt == DB_LAST) begin
                  state_n = PRESSED;
                  cnt_n   = '0;
                  evt_n   = 1'b1;
`ifdef KEYPAD_SCAN_REPEAT_EN
                  rep_n   = '0;
                  first_n = 1'b1;
`endif
               end else begin
                  cnt_n = cnt + 4'd1;
               end
            end
            PRESSED: begin
               if (idle) begin
                  state_n = RELEASE;
                  cnt_n   = '0;
               end
`ifdef KEYPAD_SCAN_REPEAT_EN
               else if (rep == (first ? REP_FIRST_LAST : REP_NEXT_LAST)) begin
                  evt_n   = 1'b1;
                  rep_n   = '0;
                  first_n = 1'b0;
               end else begin
                  rep_n = rep + 5'd1;
               end
`endif
            end
            RELEASE: begin
               if (!idle) begin
                  state_n = PRESSED;
               end else if (cnt == DB_LAST) begin
                  state_n  = SCAN;
                  cnt_n    = '0;
                  col_n    = rotate(col_out);
                  held_clr = 1'b1;
               end else begin
                  cnt_n = cnt + 4'd1;
               end
            end
            default: state_n = SCAN;
         endcase
      end
   end

   // The event is applied one edge after the FSM accepts the key.
   always_ff @(posedge CLK) begin
      if (reset) begin
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (held_clr) key_held <= 1'b0;
         if (evt) begin
            key_held <= 1'b1;
            if (!key_valid || key_ack) begin
               key_code  <= cand;
               key_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (key_ack) begin
            key_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with a physical 4x4 key-matrix model.
// Build with KEYPAD_SCAN_REPEAT_EN to exercise the auto-repeat path.
module tb_keypad_scan;

   localparam int CD = 4;
   localparam int DT = 3;
   localparam int LAT = (4 + DT) * CD + 3;
   localparam int REL = (2 + DT) * CD + 3;

   logic        CLK = 1'b0;
   logic        reset;
   logic [3:0]  col_out;
   logic [3:0]  row_in;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_ack;
   logic        key_held;
   logic        overrun;
   logic [15:0] keys;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [15:0] keys;
      logic [3:0]  code;
   } vec_t;

   vec_t tbl[6];
   logic [3:0] cols[4];

   keypad_scan #(
      .CLK_DIV(CD),
      .DEBOUNCE_TICKS(DT)
   ) dut (
      .CLK      (CLK),
      .reset    (reset),
      .col_out  (col_out),
      .row_in   (row_in),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_ack  (key_ack),
      .key_held (key_held),
      .overrun  (overrun)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // A pressed key shorts its row low while its column is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
   end

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic wait_valid(input int limit, output int n);
      n = 0;
      while (!key_valid && n <= limit) begin
         @(negedge CLK);
         n++;
      end
   endtask

   task automatic wait_unheld(input int limit, output int n);
      n = 0;
      while (key_held && n <= limit) begin
         @(negedge CLK);
         n++;
      end
   endtask

   task automatic wait_col(input logic [3:0] col);
      int n;
      n = 0;
      while (col_out !== col && n <= 4 * CD + 2) begin
         @(negedge CLK);
         n++;
      end
      check("wait_col", int'(col_out === col), 1);
   endtask

   task automatic ack_pulse();
      key_ack = 1'b1;
      @(negedge CLK);
      key_ack = 1'b0;
   endtask

   task automatic press_cycle(input logic [15:0] k, input logic [3:0] code,
                              input int dly, input string nm);
      int n;
      keys = k;
      wait_valid(LAT, n);
      check({nm, " latency"}, int'(n <= LAT), 1);
      check({nm, " code"}, key_code, code);
      check({nm, " held"}, key_held, 1);
      repeat (dly) @(negedge CLK);
      check({nm, " valid kept"}, key_valid, 1);
      ack_pulse();
      check({nm, " ack clear"}, key_valid, 0);
      keys = '0;
      wait_unheld(REL, n);
      check({nm, " release"}, int'(n >= DT * CD && n <= REL), 1);
      check({nm, " no extra"}, key_valid, 0);
   endtask

   initial begin
      int n, seen, r, r2, c, tprev;
      logic [15:0] k;

      cols[0] = 4'b1110;
      cols[1] = 4'b1101;
      cols[2] = 4'b1011;
      cols[3] = 4'b0111;
      tbl[0] = '{16'h0040, 4'd6};
      tbl[1] = '{16'h0001, 4'd0};
      tbl[2] = '{16'h8000, 4'd15};
      tbl[3] = '{16'h0808, 4'd3};
      tbl[4] = '{16'h2200, 4'd9};
      tbl[5] = '{16'h1010, 4'd4};

      reset = 1'b1;
      keys = '0;
      key_ack = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst col", col_out, 4'b1110);
      check("rst code", key_code, 0);
      check("rst valid", key_valid, 0);
      check("rst held", key_held, 0);
      check("rst overrun", overrun, 0);

      reset = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge CLK);
         check("rotate", col_out, cols[(i / 4) % 4]);
      end
      check("idle valid", key_valid, 0);

      ack_pulse();
      check("stray ack valid", key_valid, 0);
      check("stray ack code", key_code, 0);

      for (int i = 0; i < 6; i++)
         press_cycle(tbl[i].keys, tbl[i].code, i % 3, $sformatf("tbl%0d", i));

      // Short bounce: two ticks of contact, then open.
      wait_col(4'b1011);
      keys = 16'h0040;
      repeat (2 * CD) @(negedge CLK);
      keys = '0;
      seen = 0;
      repeat (15 * CD) begin
         @(negedge CLK);
         if (key_valid) seen++;
      end
      check("short bounce", seen, 0);

      // Bounce on/off for one tick each, then stable.
      wait_col(4'b1011);
      keys = 16'h0040;
      repeat (CD) @(negedge CLK);
      keys = '0;
      repeat (CD) @(negedge CLK);
      press_cycle(16'h0040, 4'd6, 0, "bounce");

      for (int i = 0; i < 8; i++) begin
         c = $urandom_range(0, 3);
         r = $urandom_range(0, 3);
         k = '0;
         k[r*4+c] = 1'b1;
         if (r < 3 && $urandom_range(0, 1) == 1) begin
            r2 = $urandom_range(r + 1, 3);
            k[r2*4+c] = 1'b1;
         end
         press_cycle(k, 4'(r * 4 + c), $urandom_range(0, 3),
                     $sformatf("rnd%0d", i));
      end

`ifdef KEYPAD_SCAN_REPEAT_EN
      keys = 16'h0040;
      wait_valid(LAT, n);
      check("rep first", int'(n <= LAT), 1);
      tprev = cyc;
      ack_pulse();
      for (int e = 1; e <= 4; e++) begin
         wait_valid(20 * CD, n);
         check("rep seen", int'(n <= 20 * CD), 1);
         check("rep gap", cyc - tprev, (e == 1) ? 16 * CD : 4 * CD);
         check("rep code", key_code, 6);
         tprev = cyc;
         ack_pulse();
      end
      keys = '0;
      wait_unheld(REL + 4 * CD, n);
`else
      keys = 16'h0040;
      wait_valid(LAT, n);
      check("single first", int'(n <= LAT), 1);
      tprev = cyc;
      ack_pulse();
      seen = 0;
      repeat (20 * CD) begin
         @(negedge CLK);
         if (key_valid) seen++;
      end
      check("no repeat", seen, 0);
      keys = '0;
      wait_unheld(REL, n);
`endif
      check("held drop", key_held, 0);
      ack_pulse();

      // Overrun: second press while the first is still un-acked.
      keys = 16'h0002;
      wait_valid(LAT, n);
      check("ovr first", int'(n <= LAT), 1);
      check("ovr code1", key_code, 1);
      keys = '0;
      wait_unheld(REL, n);
      keys = 16'h4000;
      n = 0;
      while (!key_held && n <= LAT) begin
         @(negedge CLK);
         n++;
      end
      check("ovr second", int'(n <= LAT), 1);
      check("ovr code kept", key_code, 1);
      check("ovr flag", overrun, 1);
      check("ovr valid", key_valid, 1);

      reset = 1'b1;
      @(negedge CLK);
      check("mid rst overrun", overrun, 0);
      check("mid rst valid", key_valid, 0);
      check("mid rst col", col_out, 4'b1110);
      check("mid rst held", key_held, 0);
      check("mid rst code", key_code, 0);
      keys = '0;
      reset = 1'b0;
      repeat (4) @(negedge CLK);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
